// File: rtl/reg_read_hazard_ctrl_if.sv
// ID-stage operand-read handshake between the pipeline and the register read hazard controller.
// Optional HAZ_WB_BYPASS_EN adds the bypass_sel operand-select return path.
interface reg_read_hazard_ctrl_if #(
    parameter int NREG    = 4,
    parameter int STALL_W = 16
);
    localparam int IDX_W = $clog2(NREG);

    logic               id_valid;
    logic [IDX_W-1:0]   id_rs1;
    logic               id_use_rs1;
    logic [IDX_W-1:0]   id_rs2;
    logic               id_use_rs2;
    logic [IDX_W-1:0]   id_rd;
    logic               id_wr_rd;
    logic               flush;
    logic               wb_we;
    logic [IDX_W-1:0]   wb_rd;
    logic               stall;
    logic               issue;
    logic               bubble;
    logic [NREG-1:0]    pend_mask;
    logic [STALL_W-1:0] stall_cnt;
    logic               err;
`ifdef HAZ_WB_BYPASS_EN
    logic [1:0]         bypass_sel;
`endif

    modport master (
        output id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2,
        output id_rd, id_wr_rd, flush, wb_we, wb_rd,
        input  stall, issue, bubble, pend_mask, stall_cnt, err
`ifdef HAZ_WB_BYPASS_EN
        , input bypass_sel
`endif
    );

    modport slave (
        input  id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2,
        input  id_rd, id_wr_rd, flush, wb_we, wb_rd,
        output stall, issue, bubble, pend_mask, stall_cnt, err
`ifdef HAZ_WB_BYPASS_EN
        , output bypass_sel
`endif
    );
endinterface

// File: rtl/reg_read_hazard_ctrl.sv
// Scoreboard-based read hazard controller for the 4x8 register file at the ID stage.
// Define HAZ_WB_BYPASS_EN to let a source waiting on its last in-flight write issue in the writeback cycle.
module reg_read_hazard_ctrl #(
    parameter int NREG    = 4,
    parameter int PEND_W  = 2,
    parameter int STALL_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_read_hazard_ctrl_if.slave  bus
);
    localparam int IDX_W = $clog2(NREG);
    localparam logic [PEND_W-1:0]  PEND_ZERO  = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0]  PEND_ONE   = {{(PEND_W-1){1'b0}}, 1'b1};
    localparam logic [PEND_W-1:0]  PEND_MAX   = {PEND_W{1'b1}};
    localparam logic [STALL_W-1:0] STALL_ZERO = {STALL_W{1'b0}};
    localparam logic [STALL_W-1:0] STALL_ONE  = {{(STALL_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0] STALL_MAX  = {STALL_W{1'b1}};

    logic [PEND_W-1:0]  pending_r     [NREG];
    logic [PEND_W-1:0]  pending_nxt_s [NREG];
    logic [NREG-1:0]    pend_mask_r;
    logic [NREG-1:0]    pend_mask_nxt_s;
    logic [STALL_W-1:0] stall_cnt_r;
    logic               err_r;
    logic               err_set_s;

    logic [PEND_W-1:0]  pend_rs1_s;
    logic [PEND_W-1:0]  pend_rs2_s;
    logic [PEND_W-1:0]  pend_rd_s;
    logic               byp1_s;
    logic               byp2_s;
    logic               raw1_s;
    logic               raw2_s;
    logic               full_s;
    logic               stall_s;
    logic               issue_s;
    logic               bubble_s;
    logic [NREG-1:0]    inc_s;
    logic [NREG-1:0]    dec_s;

    // Scoreboard lookup for the three operand indices of the ID instruction.
    always_comb begin
        pend_rs1_s = pending_r[bus.id_rs1];
        pend_rs2_s = pending_r[bus.id_rs2];
        pend_rd_s  = pending_r[bus.id_rd];
    end

`ifdef HAZ_WB_BYPASS_EN
    // A source is forwardable only when the write retiring now is its last outstanding one.
    always_comb begin
        byp1_s = bus.id_use_rs1 & bus.wb_we & (bus.wb_rd == bus.id_rs1) & (pend_rs1_s == PEND_ONE);
        byp2_s = bus.id_use_rs2 & bus.wb_we & (bus.wb_rd == bus.id_rs2) & (pend_rs2_s == PEND_ONE);
    end

    // Operand select only means something for an instruction that actually issues.
    always_comb begin
        bus.bypass_sel = {byp2_s, byp1_s} & {2{issue_s}};
    end
`else
    // Without forwarding no hazard is ever waived.
    always_comb begin
        byp1_s = 1'b0;
        byp2_s = 1'b0;
    end
`endif

    // Hazard evaluation and issue/stall/bubble decision.
    always_comb begin
        raw1_s   = bus.id_use_rs1 & (pend_rs1_s != PEND_ZERO) & ~byp1_s;
        raw2_s   = bus.id_use_rs2 & (pend_rs2_s != PEND_ZERO) & ~byp2_s;
        // A full destination counter must not take another writer.
        full_s   = bus.id_wr_rd & (pend_rd_s == PEND_MAX);
        stall_s  = bus.id_valid & ~bus.flush & (raw1_s | raw2_s | full_s);
        issue_s  = bus.id_valid & ~bus.flush & ~stall_s;
        bubble_s = (bus.id_valid & ~issue_s) | bus.flush;
    end

    // Per-register increment (issued writer) and decrement (writeback) strobes.
    always_comb begin
        inc_s = {NREG{1'b0}};
        dec_s = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            inc_s[i] = issue_s & bus.id_wr_rd & (bus.id_rd == IDX_W'(i));
            dec_s[i] = bus.wb_we & (bus.wb_rd == IDX_W'(i));
        end
    end

    // Next scoreboard state; out-of-range updates saturate and raise the error flag.
    always_comb begin
        err_set_s       = 1'b0;
        pend_mask_nxt_s = {NREG{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            pending_nxt_s[i] = pending_r[i];
            case ({inc_s[i], dec_s[i]})
                2'b10: begin
                    if (pending_r[i] == PEND_MAX) begin
                        pending_nxt_s[i] = PEND_MAX;
                        err_set_s        = 1'b1;
                    end else begin
                        pending_nxt_s[i] = pending_r[i] + PEND_ONE;
                    end
                end
                2'b01: begin
                    if (pending_r[i] == PEND_ZERO) begin
                        pending_nxt_s[i] = PEND_ZERO;
                        err_set_s        = 1'b1;
                    end else begin
                        pending_nxt_s[i] = pending_r[i] - PEND_ONE;
                    end
                end
                default: begin
                    pending_nxt_s[i] = pending_r[i];
                end
            endcase
            pend_mask_nxt_s[i] = (pending_nxt_s[i] != PEND_ZERO);
        end
    end

    // Scoreboard counters and their registered non-zero view.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                pending_r[i] <= PEND_ZERO;
            end
            pend_mask_r <= {NREG{1'b0}};
        end else begin
            for (int i = 0; i < NREG; i++) begin
                pending_r[i] <= pending_nxt_s[i];
            end
            pend_mask_r <= pend_mask_nxt_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_r <= STALL_ZERO;
        end else if (stall_s && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + STALL_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Sticky scoreboard error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
        end
    end

    assign bus.stall     = stall_s;
    assign bus.issue     = issue_s;
    assign bus.bubble    = bubble_s;
    assign bus.pend_mask = pend_mask_r;
    assign bus.stall_cnt = stall_cnt_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_reg_read_hazard_ctrl.sv
// Self-checking bench for reg_read_hazard_ctrl: per-cycle compare against an arithmetic scoreboard model
// plus directed scenarios with literal expectations.
module tb_reg_read_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_read_hazard_ctrl_if #(.NREG(4), .STALL_W(16)) bus ();
    reg_read_hazard_ctrl #(.NREG(4), .PEND_W(2), .STALL_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef HAZ_WB_BYPASS_EN
    localparam int EXP_ISSUE_K = 3;
    localparam int EXP_STALLS  = 2;
`else
    localparam int EXP_ISSUE_K = 4;
    localparam int EXP_STALLS  = 3;
`endif

    int checks = 0;
    int errors = 0;
    int m_pend [4];
    int m_cnt;
    bit m_err;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit m_byp(input bit use_src, input int rs);
`ifdef HAZ_WB_BYPASS_EN
        return use_src && (bus.wb_we === 1'b1) && (int'(bus.wb_rd) == rs) && (m_pend[rs] == 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_stall();
        bit h1, h2, fl;
        h1 = bus.id_use_rs1 && (m_pend[bus.id_rs1] > 0) && !m_byp(bus.id_use_rs1, int'(bus.id_rs1));
        h2 = bus.id_use_rs2 && (m_pend[bus.id_rs2] > 0) && !m_byp(bus.id_use_rs2, int'(bus.id_rs2));
        fl = bus.id_wr_rd && (m_pend[bus.id_rd] == 3);
        return bus.id_valid && !bus.flush && (h1 || h2 || fl);
    endfunction

    function automatic bit m_issue();
        return bus.id_valid && !bus.flush && !m_stall();
    endfunction

    always @(posedge clk) begin : model_upd
        int np;
        bit s, iss;
        if (rst === 1'b0) begin
            for (int i = 0; i < 4; i++) m_pend[i] <= 0;
            m_cnt    <= 0;
            m_err    <= 1'b0;
            model_on <= 1'b1;
        end else if (model_on) begin
            s   = m_stall();
            iss = m_issue();
            for (int i = 0; i < 4; i++) begin
                np = m_pend[i];
                if (iss && bus.id_wr_rd && int'(bus.id_rd) == i) np = np + 1;
                if (bus.wb_we && int'(bus.wb_rd) == i) np = np - 1;
                if (np < 0) begin np = 0; m_err <= 1'b1; end
                if (np > 3) begin np = 3; m_err <= 1'b1; end
                m_pend[i] <= np;
            end
            if (s && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk) begin : compare
        logic [3:0] e_mask;
        bit e_stall, e_issue;
        if (model_on) begin
            e_stall = m_stall();
            e_issue = m_issue();
            for (int i = 0; i < 4; i++) e_mask[i] = (m_pend[i] != 0);
            check("stall", 32'(bus.stall), 32'(e_stall));
            check("issue", 32'(bus.issue), 32'(e_issue));
            check("bubble", 32'(bus.bubble), 32'((bus.id_valid && !e_issue) || bus.flush));
            check("pend_mask", 32'(bus.pend_mask), 32'(e_mask));
            check("stall_cnt", 32'(bus.stall_cnt), 32'(m_cnt));
            check("err", 32'(bus.err), 32'(m_err));
`ifdef HAZ_WB_BYPASS_EN
            check("bypass_sel", 32'(bus.bypass_sel),
                  e_issue ? 32'({m_byp(bus.id_use_rs2, int'(bus.id_rs2)),
                                 m_byp(bus.id_use_rs1, int'(bus.id_rs1))}) : 32'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic set(input bit v, input bit u1, input int r1, input bit u2, input int r2,
                       input bit w, input int rd, input bit fl, input bit we, input int wrd);
        bus.id_valid   = v;
        bus.id_use_rs1 = u1;
        bus.id_rs1     = 2'(r1);
        bus.id_use_rs2 = u2;
        bus.id_rs2     = 2'(r2);
        bus.id_wr_rd   = w;
        bus.id_rd      = 2'(rd);
        bus.flush      = fl;
        bus.wb_we      = we;
        bus.wb_rd      = 2'(wrd);
    endtask

    task automatic idle();
        set(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic rand_in();
        set(1'($urandom), 1'($urandom), int'($urandom_range(3)), 1'($urandom), int'($urandom_range(3)),
            1'($urandom), int'($urandom_range(3)), 1'($urandom), 1'($urandom), int'($urandom_range(3)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hit;
        int base;
        rst = 1'b0;
        rand_in();
        repeat (2) begin
            tick();
            rand_in();
        end
        rst = 1'b1;
        idle();
        @(negedge clk);
        check("rst_pend_mask", 32'(bus.pend_mask), 32'd0);
        check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        tick();

        // back-to-back RAW on r2, writeback 3 cycles after issue
        base = int'(bus.stall_cnt);
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 2, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("raw_writer_issue", 32'(bus.issue), 32'd1);
        tick();
        hit = 0;
        for (int k = 1; k <= 6 && hit == 0; k++) begin
            set(1'b1, 1'b1, 2, 1'b0, 0, 1'b0, 0, 1'b0, (k == 3), 2);
            @(negedge clk);
            if (k == 1) check("raw_first_stall", 32'(bus.stall), 32'd1);
            if (bus.issue === 1'b1) begin
                hit = k;
`ifdef HAZ_WB_BYPASS_EN
                check("raw_bypass_sel", 32'(bus.bypass_sel), 32'd1);
`endif
            end
            tick();
        end
        check("raw_issue_cycle", 32'(hit), 32'(EXP_ISSUE_K));
        idle();
        @(negedge clk);
        check("raw_stall_cycles", 32'(int'(bus.stall_cnt) - base), 32'(EXP_STALLS));
        check("raw_pend_clear", 32'(bus.pend_mask), 32'd0);
        tick();

        // overflow guard on r1
        for (int j = 0; j < 3; j++) begin
            set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0, 0);
            @(negedge clk);
            check("ovf_wr_issue", 32'(bus.issue), 32'd1);
            tick();
        end
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("ovf_4th_stall", 32'(bus.stall), 32'd1);
        check("ovf_mask", 32'(bus.pend_mask), 32'b0010);
        tick();
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b1, 1);
        @(negedge clk);
        check("ovf_full_in_wb", 32'(bus.stall), 32'd1);
        tick();
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("ovf_4th_issue", 32'(bus.issue), 32'd1);
        tick();
        idle();
        @(negedge clk);
        check("ovf_mask_after", 32'(bus.pend_mask), 32'b0010);
        check("ovf_no_err", 32'(bus.err), 32'd0);
        tick();
        for (int j = 0; j < 3; j++) begin
            set(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1);
            tick();
        end
        idle();
        @(negedge clk);
        check("ovf_drained", 32'(bus.pend_mask), 32'd0);
        tick();

        // simultaneous inc/dec on r3
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0, 1'b0, 0);
        tick();
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0, 1'b1, 3);
        @(negedge clk);
        check("sim_issue", 32'(bus.issue), 32'd1);
        tick();
        idle();
        @(negedge clk);
        check("sim_mask", 32'(bus.pend_mask), 32'b1000);
        check("sim_err", 32'(bus.err), 32'd0);
        tick();
        set(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 3);
        tick();

        // rs2 hazard and id_valid=0 behaviour
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0, 1'b0, 0);
        tick();
        set(1'b0, 1'b1, 1, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("inv_no_stall", 32'(bus.stall), 32'd0);
        check("inv_no_bubble", 32'(bus.bubble), 32'd0);
        tick();
        set(1'b1, 1'b0, 0, 1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("rs2_stall", 32'(bus.stall), 32'd1);
        check("rs2_bubble", 32'(bus.bubble), 32'd1);
        tick();
        set(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1);
        tick();

        // flush then underflow
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 0);
        @(negedge clk);
        check("flush_bubble", 32'(bus.bubble), 32'd1);
        check("flush_issue", 32'(bus.issue), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("flush_mask", 32'(bus.pend_mask), 32'd0);
        tick();
        set(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 0);
        tick();
        idle();
        @(negedge clk);
        check("underflow_err", 32'(bus.err), 32'd1);
        repeat (3) tick();
        @(negedge clk);
        check("err_sticky", 32'(bus.err), 32'd1);
        tick();

        // reset in the middle of a stall
        set(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 0);
        tick();
        set(1'b1, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("mid_stall", 32'(bus.stall), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_stall", 32'(bus.stall), 32'd0);
        check("post_rst_issue", 32'(bus.issue), 32'd1);
        check("post_rst_err", 32'(bus.err), 32'd0);
        check("post_rst_cnt", 32'(bus.stall_cnt), 32'd0);
        tick();
        idle();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_read_hazard_ctrl.md
Name: reg_read_hazard_ctrl

Overview:
- Read-side controller for the 4x8 main register file. It sits at the ID stage, ahead of the ID/EXE stage register.
- Keeps a per-register scoreboard of writes still in flight (issued from ID, not yet written back at WB).
- Decides each cycle whether the ID instruction may read its operands and issue, or must stall IF/ID and inject a bubble into ID/EXE.
- Writeback events retire scoreboard entries. This closes the loop from the register-file writer back to the reader.

Parameters:
- NREG, 4, number of architectural registers; index width is 2 bits.
- PEND_W, 2, width of each pending counter; maximum in-flight writes per register is 3.
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset; sampled on posedge clk.
- id_valid  input  1  the ID stage holds a real instruction.
- id_rs1  input  2  first source register index.
- id_use_rs1  input  1  the instruction reads rs1.
- id_rs2  input  2  second source register index.
- id_use_rs2  input  1  the instruction reads rs2.
- id_rd  input  2  destination register index.
- id_wr_rd  input  1  the instruction writes rd.
- flush  input  1  squash the current ID instruction (branch/CALL/RETURN redirect).
- wb_we  input  1  WB is writing the register file this cycle.
- wb_rd  input  2  WB destination index.
- stall  output  1  hold IF/ID and the PC; combinational.
- issue  output  1  the ID instruction advances into ID/EXE this cycle; combinational.
- bubble  output  1  load a NOP into ID/EXE; combinational; equals id_valid & ~issue, or flush.
- pend_mask  output  4  bit i = 1 while pending[i] != 0; registered view.
- stall_cnt  output  STALL_W  saturating count of stall cycles; registered.
- err  output  1  sticky scoreboard underflow/overflow flag; registered.

Behaviour:
- State:
  - pending[0..3], each PEND_W bits.
  - stall_cnt.
  - err.
- Reset (rst=0 at posedge): pending all 0, stall_cnt=0, err=0. Reset wins over every other event in the same cycle. This holds mid-stall too: stall deasserts in the cycle after reset.
- Hazard terms, combinational from registered pending:
  - raw1 = id_use_rs1 & (pending[id_rs1] != 0)
  - raw2 = id_use_rs2 & (pending[id_rs2] != 0)
  - full = id_wr_rd & (pending[id_rd] == 3)
- stall = id_valid & ~flush & (raw1 | raw2 | full).
- issue = id_valid & ~flush & ~stall.
- Scoreboard update at posedge:
  - inc = issue & id_wr_rd, targeting id_rd.
  - dec = wb_we, targeting wb_rd.
  - inc and dec on the same register in the same cycle: net 0, no error.
  - dec on a register with pending=0: counter stays 0, err<=1.
  - full prevents any increment past 3. If an overflow is ever computed anyway, err<=1 and the counter saturates.
- Latency:
  - An issued writer sets its pend_mask bit visible from the next cycle.
  - A dependent instruction in ID the very next cycle stalls.
  - Stall releases in the cycle after the matching wb_we posedge, unless the bypass feature is compiled in.
- flush:
  - Squashes the ID instruction: no issue, no increment, bubble=1.
  - Instructions already in flight still retire through wb_we; flush does not clear pending.
- stall_cnt:
  - Increments by 1 on each posedge where stall=1.
  - Saturates at all-ones with no wrap.
  - Counts only while rst=1.
- err clears only on reset.
- id_valid=0: stall=0, issue=0, bubble=0. The scoreboard still decrements on wb_we.

Optional Feature:
- Macro HAZ_WB_BYPASS_EN.
- When defined:
  - A source hazard is suppressed when wb_we=1, wb_rd equals that source, and pending[source]==1. That is, the last outstanding write is completing this cycle.
  - Output bypass_sel[1:0] is added: bit0 selects the WB data onto operand 1, bit1 onto operand 2.
  - The instruction issues in the same cycle as the writeback, saving 1 cycle per such dependency.
- When undefined:
  - No bypass_sel port.
  - The instruction stalls through the writeback cycle and issues in the following cycle.

Test Plan:
- Reset:
  - Drive rst=0 for 2 cycles with random inputs active, then rst=1.
  - Required: pend_mask=0000, stall_cnt=0, err=0, stall=0.
- Back-to-back RAW, feature off:
  - Issue a write to r2, then an instruction reading rs1=r2. wb_we/wb_rd=2 arrives 3 cycles after issue.
  - Required: stall=1 for 3 cycles, issue in the 4th cycle, stall_cnt=3.
- Same RAW case with HAZ_WB_BYPASS_EN:
  - Required: stall=1 for 2 cycles, issue in the writeback cycle with bypass_sel=01, stall_cnt=2.
- Overflow guard:
  - Issue 3 writes to r1 with no writeback, then a 4th write to r1.
  - Required: stall=1 on the 4th write; pending[1] stays 3.
  - Then wb_we with wb_rd=1: the 4th write issues next cycle, pend_mask bit1 stays 1.
- Simultaneous inc/dec:
  - With pending[3]=1, issue a write to r3 in the same cycle as wb_we with wb_rd=3.
  - Required: pending[3] stays 1, err=0.
- Flush and underflow:
  - flush=1 with id_valid=1 and id_wr_rd=1, id_rd=0: required bubble=1, issue=0, pend_mask unchanged.
  - Then wb_we with wb_rd=0 while pending[0]=0: required err=1, sticky until reset.
